// File: rtl/insertion_sort_pkg.sv
// Shared state codes, select encodings and response constants for the insertion-sort controller.
package insertion_sort_pkg;

    localparam int unsigned STATE_WDTH = 4;

    typedef logic [STATE_WDTH-1:0] state_t;

    localparam state_t S_IDLE     = 4'd0;
    localparam state_t S_INIT_I   = 4'd1;
    localparam state_t S_CHK_I    = 4'd2;
    localparam state_t S_RD_KEY_A = 4'd3;
    localparam state_t S_RD_KEY_D = 4'd4;
    localparam state_t S_CHK_J    = 4'd5;
    localparam state_t S_RD_CMP_A = 4'd6;
    localparam state_t S_RD_CMP_D = 4'd7;
    localparam state_t S_CMP      = 4'd8;
    localparam state_t S_WR_SH    = 4'd9;
    localparam state_t S_DEC_J    = 4'd10;
    localparam state_t S_PREP_KEY = 4'd11;
    localparam state_t S_WR_KEY   = 4'd12;
    localparam state_t S_INC_I    = 4'd13;
    localparam state_t S_FIN      = 4'd14;

    // Select lines: 0 picks the first-named source in the port name.
    localparam logic SEL_FIRST  = 1'b0;
    localparam logic SEL_SECOND = 1'b1;

    localparam logic RESP_OKAY = 1'b0;

endpackage

// File: rtl/wr_chan_tracker.sv
// Runs one AW/W/B write transaction: AW and W complete independently, then B is accepted.
module wr_chan_tracker
    import insertion_sort_pkg::*;
#(
    parameter int unsigned RESP_WDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go,
    output logic                 aw_valid,
    input  logic                 aw_ready,
    output logic                 w_valid,
    input  logic                 w_ready,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [RESP_WDTH-1:0] b_resp,
    output logic                 wr_done,
    output logic                 wr_err
);

    logic aw_done;
    logic w_done;

    // Completion flags clear whenever the controller leaves the write state.
    always_ff @(posedge clk) begin
        if (rst_n || !go || wr_done) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_valid && aw_ready) aw_done <= 1'b1;
            if (w_valid && w_ready)   w_done  <= 1'b1;
        end
    end

    assign aw_valid = go && !aw_done;
    assign w_valid  = go && !w_done;
    assign b_ready  = go && aw_done && w_done;
    assign wr_done  = b_ready && b_valid;
    assign wr_err   = wr_done && (b_resp != RESP_WDTH'(RESP_OKAY));

endmodule

// File: rtl/insertion_sort_ctrl.sv
// Sequencing FSM for the insertion-sort datapath: outer i loop, inner j loop and memory handshakes.
module insertion_sort_ctrl
    import insertion_sort_pkg::*;
#(
    parameter int unsigned ADDR_WDTH = 4,
    parameter int unsigned DATA_WDTH = 32,
    parameter int unsigned RESP_WDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    input  logic                 elem2insert_gt_elem2compare,
    input  logic                 j_gte_0,
    input  logic                 i_lt_arr_size,
    output logic                 sl_1_incd_to_i,
    output logic                 ld_i,
    output logic                 sl_i_minus_1_decrd_to_j,
    output logic                 ld_j,
    output logic                 ld_elem2insert,
    output logic                 ld_elem2compare,
    output logic                 sl_i_j_to_arg_read_addr,
    output logic                 ld_arg_read_addr,
    output logic                 sl_j_j_plus_1_to_arg_write_addr,
    output logic                 ld_arg_write_addr,
    output logic                 sl_elem2insert_elem2compare_to_arg_write_data,
    output logic                 ld_arg_write_data,
    output logic                 ar_valid,
    input  logic                 ar_ready,
    input  logic                 r_valid,
    output logic                 r_ready,
    output logic                 aw_valid,
    input  logic                 aw_ready,
    output logic                 w_valid,
    input  logic                 w_ready,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [RESP_WDTH-1:0] b_resp
);

    // Datapath widths are carried for interface consistency only.
    if (ADDR_WDTH == 0 || DATA_WDTH == 0) begin : g_width_unused
    end

    state_t state;
    state_t state_nxt;
    logic   wr_go;
    logic   wr_done;
    logic   wr_err;

    always_ff @(posedge clk) begin
        if (rst_n) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt                                     = state;
        sl_1_incd_to_i                                = SEL_FIRST;
        ld_i                                          = 1'b0;
        sl_i_minus_1_decrd_to_j                       = SEL_FIRST;
        ld_j                                          = 1'b0;
        ld_elem2insert                                = 1'b0;
        ld_elem2compare                               = 1'b0;
        sl_i_j_to_arg_read_addr                       = SEL_FIRST;
        ld_arg_read_addr                              = 1'b0;
        sl_j_j_plus_1_to_arg_write_addr               = SEL_FIRST;
        ld_arg_write_addr                             = 1'b0;
        sl_elem2insert_elem2compare_to_arg_write_data = SEL_FIRST;
        ld_arg_write_data                             = 1'b0;
        ar_valid                                      = 1'b0;
        r_ready                                       = 1'b0;
        wr_go                                         = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_INIT_I;
            S_INIT_I: begin
                ld_i           = 1'b1;
                sl_1_incd_to_i = SEL_FIRST;
                state_nxt      = S_CHK_I;
            end
            S_CHK_I: begin
                if (!i_lt_arr_size) begin
                    state_nxt = S_FIN;
                end else begin
                    ld_arg_read_addr        = 1'b1;
                    sl_i_j_to_arg_read_addr = SEL_FIRST;
                    state_nxt               = S_RD_KEY_A;
                end
            end
            S_RD_KEY_A: begin
                ar_valid = 1'b1;
                if (ar_ready) state_nxt = S_RD_KEY_D;
            end
            S_RD_KEY_D: begin
                r_ready = 1'b1;
                if (r_valid) begin
                    ld_elem2insert          = 1'b1;
                    ld_j                    = 1'b1;
                    sl_i_minus_1_decrd_to_j = SEL_FIRST;
                    state_nxt               = S_CHK_J;
                end
            end
            S_CHK_J: begin
                if (!j_gte_0) begin
                    state_nxt = S_PREP_KEY;
                end else begin
                    ld_arg_read_addr        = 1'b1;
                    sl_i_j_to_arg_read_addr = SEL_SECOND;
                    state_nxt               = S_RD_CMP_A;
                end
            end
            S_RD_CMP_A: begin
                ar_valid = 1'b1;
                if (ar_ready) state_nxt = S_RD_CMP_D;
            end
            S_RD_CMP_D: begin
                r_ready = 1'b1;
                if (r_valid) begin
                    ld_elem2compare = 1'b1;
                    state_nxt       = S_CMP;
                end
            end
            S_CMP: begin
                if (elem2insert_gt_elem2compare) begin
                    state_nxt = S_PREP_KEY;
                end else begin
                    ld_arg_write_addr                             = 1'b1;
                    sl_j_j_plus_1_to_arg_write_addr               = SEL_SECOND;
                    ld_arg_write_data                             = 1'b1;
                    sl_elem2insert_elem2compare_to_arg_write_data = SEL_SECOND;
                    state_nxt                                     = S_WR_SH;
                end
            end
            S_WR_SH: begin
                wr_go = 1'b1;
                if (wr_err)       state_nxt = S_FIN;
                else if (wr_done) state_nxt = S_DEC_J;
            end
            S_DEC_J: begin
                ld_j                    = 1'b1;
                sl_i_minus_1_decrd_to_j = SEL_SECOND;
                state_nxt               = S_CHK_J;
            end
            S_PREP_KEY: begin
                ld_arg_write_addr                             = 1'b1;
                sl_j_j_plus_1_to_arg_write_addr               = SEL_SECOND;
                ld_arg_write_data                             = 1'b1;
                sl_elem2insert_elem2compare_to_arg_write_data = SEL_FIRST;
                state_nxt                                     = S_WR_KEY;
            end
            S_WR_KEY: begin
                wr_go = 1'b1;
                if (wr_err)       state_nxt = S_FIN;
                else if (wr_done) state_nxt = S_INC_I;
            end
            S_INC_I: begin
                ld_i           = 1'b1;
                sl_1_incd_to_i = SEL_SECOND;
                state_nxt      = S_CHK_I;
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Sticky write-response error, cleared when a new sort is accepted.
    always_ff @(posedge clk) begin
        if (rst_n)                         error <= 1'b0;
        else if (state == S_IDLE && start) error <= 1'b0;
        else if (wr_err)                   error <= 1'b1;
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_FIN);

    wr_chan_tracker #(
        .RESP_WDTH (RESP_WDTH)
    ) u_wr_chan_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (wr_go),
        .aw_valid (aw_valid),
        .aw_ready (aw_ready),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_resp   (b_resp),
        .wr_done  (wr_done),
        .wr_err   (wr_err)
    );

endmodule

// File: tb/tb_insertion_sort_ctrl.sv
// Bench for insertion_sort_ctrl: behavioural datapath and memory, write scoreboard, handshake monitor.
module tb_insertion_sort_ctrl;

    localparam int unsigned ADDR_WDTH = 4;
    localparam int unsigned DATA_WDTH = 32;
    localparam int unsigned RESP_WDTH = 1;
    localparam int unsigned MEM_DEPTH = 16;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic busy, done, error;
    logic elem2insert_gt_elem2compare, j_gte_0, i_lt_arr_size;
    logic sl_1_incd_to_i, ld_i, sl_i_minus_1_decrd_to_j, ld_j, ld_elem2insert, ld_elem2compare;
    logic sl_i_j_to_arg_read_addr, ld_arg_read_addr, sl_j_j_plus_1_to_arg_write_addr, ld_arg_write_addr;
    logic sl_elem2insert_elem2compare_to_arg_write_data, ld_arg_write_data;
    logic ar_valid, ar_ready, r_valid, r_ready, aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic [RESP_WDTH-1:0] b_resp;
    logic [19:0] out_vec;

    always #5 clk = ~clk;

    insertion_sort_ctrl #(
        .ADDR_WDTH (ADDR_WDTH),
        .DATA_WDTH (DATA_WDTH),
        .RESP_WDTH (RESP_WDTH)
    ) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .busy (busy), .done (done), .error (error),
        .elem2insert_gt_elem2compare (elem2insert_gt_elem2compare),
        .j_gte_0 (j_gte_0), .i_lt_arr_size (i_lt_arr_size),
        .sl_1_incd_to_i (sl_1_incd_to_i), .ld_i (ld_i),
        .sl_i_minus_1_decrd_to_j (sl_i_minus_1_decrd_to_j), .ld_j (ld_j),
        .ld_elem2insert (ld_elem2insert), .ld_elem2compare (ld_elem2compare),
        .sl_i_j_to_arg_read_addr (sl_i_j_to_arg_read_addr), .ld_arg_read_addr (ld_arg_read_addr),
        .sl_j_j_plus_1_to_arg_write_addr (sl_j_j_plus_1_to_arg_write_addr),
        .ld_arg_write_addr (ld_arg_write_addr),
        .sl_elem2insert_elem2compare_to_arg_write_data (sl_elem2insert_elem2compare_to_arg_write_data),
        .ld_arg_write_data (ld_arg_write_data),
        .ar_valid (ar_valid), .ar_ready (ar_ready), .r_valid (r_valid), .r_ready (r_ready),
        .aw_valid (aw_valid), .aw_ready (aw_ready), .w_valid (w_valid), .w_ready (w_ready),
        .b_valid (b_valid), .b_ready (b_ready), .b_resp (b_resp)
    );

    assign out_vec = {busy, done, error, sl_1_incd_to_i, ld_i, sl_i_minus_1_decrd_to_j, ld_j,
                      ld_elem2insert, ld_elem2compare, sl_i_j_to_arg_read_addr, ld_arg_read_addr,
                      sl_j_j_plus_1_to_arg_write_addr, ld_arg_write_addr,
                      sl_elem2insert_elem2compare_to_arg_write_data, ld_arg_write_data,
                      ar_valid, r_ready, aw_valid, w_valid, b_ready};

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bench control
    int bp_mode = 0;        // 0: readies tied high, 1: random backpressure, 2: aw_ready held low
    int err_at = -1;
    int arr_size = 0;
    bit hold_en = 1'b0;

    // Behavioural datapath
    int          i_reg, j_reg, raddr_reg, waddr_reg;
    logic [31:0] key_reg, cmp_reg, wdata_reg, r_data;
    logic [31:0] mem [MEM_DEPTH];

    assign elem2insert_gt_elem2compare = key_reg > cmp_reg;
    assign j_gte_0       = j_reg >= 0;
    assign i_lt_arr_size = i_reg < arr_size;

    always @(posedge clk) begin
        if (rst_n) begin
            i_reg <= 0; j_reg <= 0; raddr_reg <= 0; waddr_reg <= 0;
            key_reg <= '0; cmp_reg <= '0; wdata_reg <= '0;
        end else begin
            if (ld_i)              i_reg     <= sl_1_incd_to_i ? i_reg + 1 : 1;
            if (ld_j)              j_reg     <= sl_i_minus_1_decrd_to_j ? j_reg - 1 : i_reg - 1;
            if (ld_elem2insert)    key_reg   <= r_data;
            if (ld_elem2compare)   cmp_reg   <= r_data;
            if (ld_arg_read_addr)  raddr_reg <= sl_i_j_to_arg_read_addr ? j_reg : i_reg;
            if (ld_arg_write_addr) waddr_reg <= sl_j_j_plus_1_to_arg_write_addr ? j_reg + 1 : j_reg;
            if (ld_arg_write_data)
                wdata_reg <= sl_elem2insert_elem2compare_to_arg_write_data ? cmp_reg : key_reg;
        end
    end

    // Memory slave
    function automatic logic pick_ready();
        return (bp_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    function automatic int pick_delay();
        return (bp_mode == 1) ? int'($urandom_range(0, 5)) : 0;
    endfunction

    logic        rd_pend = 1'b0, aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0;
    int          rd_wait = 0, b_wait = 0, rd_addr = 0, aw_cap = 0, wr_idx = 0, err_hs_cnt = 0;
    logic [31:0] w_cap = '0;
    wr_t         wr_log [$];
    wr_t         exp_q [$];

    always @(posedge clk) begin
        ar_ready <= pick_ready();
        w_ready  <= pick_ready();
        aw_ready <= (bp_mode == 2) ? 1'b0 : pick_ready();
        if (rst_n) begin
            rd_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0;
            r_valid <= 1'b0; b_valid <= 1'b0; b_resp <= '0; r_data <= '0;
        end else begin
            if (ar_valid && ar_ready) begin
                rd_pend <= 1'b1;
                rd_wait <= pick_delay();
                rd_addr <= raddr_reg;
            end
            if (rd_pend && !r_valid) begin
                if (rd_wait == 0) begin
                    r_valid <= 1'b1;
                    r_data  <= mem[rd_addr];
                    rd_pend <= 1'b0;
                end else begin
                    rd_wait <= rd_wait - 1;
                end
            end
            if (r_valid && r_ready) r_valid <= 1'b0;
            if (aw_valid && aw_ready) begin aw_got <= 1'b1; aw_cap <= waddr_reg; end
            if (w_valid && w_ready)   begin w_got  <= 1'b1; w_cap  <= wdata_reg; end
            if (aw_got && w_got && !b_pend && !b_valid) begin
                b_pend <= 1'b1;
                b_wait <= pick_delay();
            end
            if (b_pend) begin
                if (b_wait == 0) begin
                    b_valid <= 1'b1;
                    b_resp  <= RESP_WDTH'(wr_idx == err_at);
                    b_pend  <= 1'b0;
                end else begin
                    b_wait <= b_wait - 1;
                end
            end
            if (b_valid && b_ready) begin
                b_valid     <= 1'b0;
                aw_got      <= 1'b0;
                w_got       <= 1'b0;
                mem[aw_cap] <= w_cap;
                wr_idx      <= wr_idx + 1;
                if (b_resp != '0) err_hs_cnt <= err_hs_cnt + 1;
                wr_log.push_back('{addr: aw_cap, data: w_cap});
            end
        end
    end

    // Monitor: scoreboard, valid stability, error-abort timing, activity counters
    int done_cnt = 0, ar_seen = 0, aw_seen = 0, w_seen = 0, n_writes = 0;

    initial begin
        bit  p_ok, p_ar, p_aw, p_w;
        int  err_seen;
        wr_t got, want;
        p_ok = 0; p_ar = 0; p_aw = 0; p_w = 0; err_seen = 0;
        forever begin
            @(negedge clk);
            if (done)     done_cnt++;
            if (ar_valid) ar_seen++;
            if (aw_valid) aw_seen++;
            if (w_valid)  w_seen++;
            while (wr_log.size() > 0) begin
                got = wr_log.pop_front();
                n_writes++;
                check("wr_unexpected", 32'(exp_q.size() == 0), 32'd0);
                if (exp_q.size() > 0) begin
                    want = exp_q.pop_front();
                    check("wr_addr", 32'(got.addr), 32'(want.addr));
                    check("wr_data", got.data, want.data);
                end
            end
            if (err_hs_cnt != err_seen) begin
                err_seen = err_hs_cnt;
                check("err_fin_done", 32'(done), 32'd1);
                check("err_fin_error", 32'(error), 32'd1);
            end
            if (p_ok && hold_en && !rst_n) begin
                if (p_ar) check("ar_hold", 32'(ar_valid), 32'd1);
                if (p_aw) check("aw_hold", 32'(aw_valid), 32'd1);
                if (p_w)  check("w_hold", 32'(w_valid), 32'd1);
            end
            p_ok = hold_en && !rst_n;
            p_ar = ar_valid && !ar_ready;
            p_aw = aw_valid && !aw_ready;
            p_w  = w_valid && !w_ready;
        end
    end

    // Reference insertion sort; pushes each expected write, stopping after an erroring one.
    task automatic run_sort(input logic [31:0] a [MEM_DEPTH], input int n, input int err_k);
        logic [31:0] r [MEM_DEPTH];
        logic [31:0] key;
        int          jj, pushed, d0;
        bit          stop;
        r = a; pushed = 0; stop = 0;
        for (int i = 1; i < n && !stop; i++) begin
            key = r[i];
            jj  = i - 1;
            while (jj >= 0 && !(key > r[jj]) && !stop) begin
                exp_q.push_back('{addr: jj + 1, data: r[jj]});
                pushed++;
                if (err_k >= 0 && pushed > err_k) stop = 1;
                r[jj + 1] = r[jj];
                jj--;
            end
            if (!stop) begin
                exp_q.push_back('{addr: jj + 1, data: key});
                pushed++;
                if (err_k >= 0 && pushed > err_k) stop = 1;
                r[jj + 1] = key;
            end
        end
        @(negedge clk);
        for (int k = 0; k < int'(MEM_DEPTH); k++) mem[k] <= a[k];
        arr_size = n;
        err_at   = (err_k < 0) ? -1 : wr_idx + err_k;
        d0       = done_cnt;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (done) break;
            @(negedge clk);
        end
        check("done_seen", 32'(done), 32'd1);
        repeat (2) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        if (err_k < 0) begin
            check("done_pulses", 32'(done_cnt - d0), 32'd1);
            for (int k = 0; k < n; k++) check("mem_final", mem[k], r[k]);
        end
    endtask

    // Degenerate array: fixed T+3 done, no memory traffic, error cleared by start.
    task automatic short_sort(input int n);
        int a0, aw0, w0;
        arr_size = n;
        a0 = ar_seen; aw0 = aw_seen; w0 = w_seen;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_done", 32'(done), 32'd0);
        check("t1_err_clr", 32'(error), 32'd0);
        @(negedge clk);
        check("t2_done", 32'(done), 32'd0);
        @(negedge clk);
        check("t3_done", 32'(done), 32'd1);
        @(negedge clk);
        check("t4_idle", 32'({busy, done}), 32'd0);
        check("no_ar", 32'(ar_seen - a0), 32'd0);
        check("no_aw", 32'(aw_seen - aw0), 32'd0);
        check("no_w", 32'(w_seen - w0), 32'd0);
    endtask

    initial begin
        logic [31:0] arr [MEM_DEPTH];
        int          nw0, n;
        repeat (3) @(negedge clk);
        check("rst_outputs", 32'(out_vec), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("idle_outputs", 32'(out_vec), 32'd0);

        short_sort(0);
        short_sort(1);

        foreach (arr[k]) arr[k] = '0;
        arr[0] = 3; arr[1] = 1; arr[2] = 2;
        run_sort(arr, 3, -1);

        arr[0] = 1; arr[1] = 2; arr[2] = 3; arr[3] = 4;
        nw0 = n_writes;
        run_sort(arr, 4, -1);
        check("sorted_nwrites", 32'(n_writes - nw0), 32'd3);

        // Error response on the second write aborts the sort.
        arr[0] = 3; arr[1] = 1; arr[2] = 2; arr[3] = 0;
        nw0 = n_writes;
        run_sort(arr, 3, 1);
        check("err_nwrites", 32'(n_writes - nw0), 32'd2);
        check("err_sticky", 32'({busy, error}), 32'd1);
        short_sort(0);

        // Reset while a write address is stalled.
        bp_mode = 2;
        @(negedge clk);
        for (int k = 0; k < int'(MEM_DEPTH); k++) mem[k] <= arr[k];
        arr_size = 3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (aw_valid) break;
            @(negedge clk);
        end
        check("aw_pending", 32'(aw_valid), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_outputs", 32'(out_vec), 32'd0);
        rst_n   = 1'b0;
        bp_mode = 0;
        run_sort(arr, 3, -1);

        // Random arrays under backpressure.
        bp_mode = 1;
        hold_en = 1'b1;
        for (int t = 0; t < 100; t++) begin
            foreach (arr[k]) arr[k] = '0;
            n = int'($urandom_range(2, 6));
            for (int k = 0; k < n; k++) arr[k] = 32'($urandom_range(0, 9));
            run_sort(arr, n, -1);
        end
        hold_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/insertion_sort_ctrl.md
# insertion_sort_ctrl

Sequencing FSM for the insertion-sort datapath. It walks the outer `i` loop and the inner `j` loop, drives every register-load and mux-select line of the datapath, and performs the valid/ready handshakes on the memory AR/R/AW/W/B channels. The datapath returns its comparison flags to this block. The block sits between the top-level start/done interface and the datapath/memory pair.

## Interface
- `ADDR_WDTH`, 4, array address width (passed through for consistency; not used internally)
- `DATA_WDTH`, 32, element width (not used internally)
- `RESP_WDTH`, 1, write-response width
- `clk` in 1: the single clock
- `rst_n` in 1: synchronous, **active-high** reset (the name is historical; polarity and synchronicity are fixed)
- `start` in 1: begin a sort; sampled only in IDLE
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse on completion
- `error` out 1: sticky; set on a nonzero `b_resp`, cleared by the next accepted `start`
- `elem2insert_gt_elem2compare`, `j_gte_0`, `i_lt_arr_size` in 1 each: datapath flags, combinational from the datapath registers
- `sl_1_incd_to_i`, `ld_i`, `sl_i_minus_1_decrd_to_j`, `ld_j`, `ld_elem2insert`, `ld_elem2compare`, `sl_i_j_to_arg_read_addr`, `ld_arg_read_addr`, `sl_j_j_plus_1_to_arg_write_addr`, `ld_arg_write_addr`, `sl_elem2insert_elem2compare_to_arg_write_data`, `ld_arg_write_data` out 1 each
  - Select encoding: 0 chooses the first-named source.
- `ar_valid` out 1, `ar_ready` in 1
- `r_valid` in 1, `r_ready` out 1
- `aw_valid` out 1, `aw_ready` in 1
- `w_valid` out 1, `w_ready` in 1
- `b_valid` in 1, `b_ready` out 1, `b_resp` in RESP_WDTH

## Operation
- Algorithm, per outer iteration:
  - Take `key = a[i]` and set `j = i-1`.
  - While `j>=0` and `!elem2insert_gt_elem2compare`: write `a[j+1] = a[j]`, then decrement `j`.
  - Write `a[j+1] = key`.
  - Equal keys are shifted, so the sort is not stable but the result is ordered.
- States, in order:
  - IDLE: on `start`, go to INIT_I.
  - INIT_I: `ld_i`, sel 1 → CHK_I.
  - CHK_I: `!i_lt_arr_size` → FIN; otherwise `ld_arg_read_addr` sel i → RD_KEY_A.
  - RD_KEY_A: hold `ar_valid` until `ar_ready` → RD_KEY_D.
  - RD_KEY_D: `r_ready=1`; on `r_valid`, `ld_elem2insert` and `ld_j` sel i-1 → CHK_J.
  - CHK_J: `!j_gte_0` → PREP_KEY; otherwise `ld_arg_read_addr` sel j → RD_CMP_A.
  - RD_CMP_A → RD_CMP_D: same handshake as the key read; on `r_valid`, `ld_elem2compare` → CMP.
  - CMP: if `elem2insert_gt_elem2compare` → PREP_KEY; otherwise `ld_arg_write_addr` sel j+1 and `ld_arg_write_data` sel elem2compare → WR_SH.
  - WR_SH: write transaction, then → DEC_J.
  - DEC_J: `ld_j` sel decrement → CHK_J.
  - PREP_KEY: `ld_arg_write_addr` sel j+1 and `ld_arg_write_data` sel elem2insert → WR_KEY.
  - WR_KEY: write transaction, then → INC_I.
  - INC_I: `ld_i` sel increment → CHK_I.
  - FIN: `done=1` → IDLE.
- Write transaction:
  - `aw_valid` and `w_valid` assert together.
  - Each drops independently on its own ready.
  - Once both have completed, `b_ready=1` until `b_valid`.
  - A nonzero `b_resp` sets `error` and forces FIN; the sort is aborted.
- Load and select outputs are zero in every state not listed above.

## Timing
- Reset: state = IDLE. Every output is 0, including `busy`, `done`, `error` and all valids.
- Reset mid-operation: return to IDLE the next cycle; any outstanding valid drops immediately.
- A load asserted in cycle N is visible in the registers, and in the flags, in cycle N+1. Flags are evaluated only in CHK_I, CHK_J and CMP.
- Valids assert the cycle after the address or data register loads.
- A valid never drops before its ready, and once asserted it stays high until that ready (no de-assertion without the matching ready).
- `ready=1` on the same cycle as valid completes the handshake in that cycle.
- `arr_size` ≤ 1:
  - `start` at T; INIT_I at T+1; CHK_I at T+2; FIN (`done`) at T+3; IDLE at T+4.
  - No memory traffic occurs.
- `start` while busy is ignored.
- `ld_j` sel decrement at `j=0` yields the negative value; `j_gte_0` then terminates the inner loop.

## Structure
- `insertion_sort_pkg`:
  - state enum
  - select constants: `SEL_FIRST=0`, `SEL_SECOND=1`
  - `RESP_OKAY='0`
- One sub-module, `wr_chan_tracker`, tracks AW/W completion independently. It has `go`, the channel handshakes and `b_*`, and outputs `wr_done` and `wr_err`.
- Controller FSM in the top; outputs decoded from registered state (Moore, except the ready/valid completion terms).

## Test plan
- `arr_size=0` and `arr_size=1` → `done` at exactly T+3, with `ar_valid`, `aw_valid` and `w_valid` never high.
- Memory {3,1,2}, `arr_size=3`, all readies tied 1:
  - Writes, in order: (1,3), (0,1), (2,3), (1,2).
  - Final memory {1,2,3}.
  - Single `done` pulse.
- Already sorted {1,2,3,4}:
  - Three key writes only, to addresses 1, 2, 3 (key written back to its own slot).
  - Zero shift writes.
- Random backpressure on each ready and `r_valid`/`b_valid` delays of 0–5 cycles:
  - Valids stay stable until their ready.
  - Result matches the reference model across 100 random arrays.
- `b_resp=1` on the second write → `error=1` and FIN the next cycle; `error` clears on the next `start`.
- `rst_n=1` while `aw_valid` is pending → the cycle after: IDLE, all outputs 0.
